// File: rtl/ifetch_prefetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one fetch in flight and buffers words in an in-order queue.
// Optional redirect/stall performance counters are built when IFETCH_PERF_CNT_EN is defined.
module ifetch_prefetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction,
   output logic [31:0] ins_pc,
   output logic        ins_valid,
   input  logic        ins_ready,
   input  logic        Branch,
   input  logic        zero,
   input  logic        Jump,
   output logic [15:0] flush_cnt,
   output logic [15:0] stall_cnt
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
   logic [31:0]   r_q_ins [DEPTH];
   logic [31:0]   r_q_pc  [DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW-1:0] w_count;
   logic          w_full, w_consume, w_redirect, w_push, w_req;
   logic [31:0]   w_head_ins, w_head_pc, w_pc4, w_br_off, w_target;

   assign w_count    = r_wr_ptr - r_rd_ptr;
   assign w_full     = (w_count == PW'(DEPTH));
   assign ins_valid  = (r_wr_ptr != r_rd_ptr);
   assign w_head_ins = r_q_ins[r_rd_ptr[AW-1:0]];
   assign w_head_pc  = r_q_pc[r_rd_ptr[AW-1:0]];
   assign Instruction = ins_valid ? w_head_ins : 32'd0;
   assign ins_pc      = ins_valid ? w_head_pc  : 32'd0;

   // Redirect decode for the instruction being consumed; Jump wins over a taken branch
   assign w_consume  = ins_valid & ins_ready;
   assign w_redirect = w_consume & (Jump | (Branch & zero));
   assign w_pc4      = w_head_pc + 32'd4;
   assign w_br_off   = {{14{w_head_ins[15]}}, w_head_ins[15:0], 2'b00};
   assign w_target   = Jump ? {w_pc4[31:28], w_head_ins[25:0], 2'b00} : (w_pc4 + w_br_off);

   // Fetch FSM next-state; an in-flight fetch that gets redirected must be drained in DROP
   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_req          = 1'b0;
      w_push         = 1'b0;
      case (r_state)
         IDLE: begin
            w_req = reset & ~w_full & ~w_redirect;
            if (w_req && imem_ready) begin
               w_state_nxt    = WAIT;
               w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               w_state_nxt = IDLE;
               w_push      = ~w_redirect;
            end
         end
         DROP: begin
            if (imem_rvalid) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_redirect) begin
         w_fetch_pc_nxt = w_target;
         w_state_nxt    = ((r_state != IDLE) && !imem_rvalid) ? DROP : IDLE;
      end
   end

   assign imem_req  = w_req;
   assign imem_addr = r_fetch_pc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_fetch_pc <= RESET_PC;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         if (w_redirect) begin
            r_rd_ptr <= r_wr_ptr;
         end else begin
            if (w_push)    r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_consume) r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   // Queue storage; the outstanding address is fetch_pc-4 because fetch_pc advanced on accept
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_ins[r_wr_ptr[AW-1:0]] <= imem_rdata;
         r_q_pc[r_wr_ptr[AW-1:0]]  <= r_fetch_pc - 32'd4;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [15:0] r_flush_cnt, r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_flush_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_redirect && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
         if (!ins_valid && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign flush_cnt = r_flush_cnt;
   assign stall_cnt = r_stall_cnt;
`else
   assign flush_cnt = 16'd0;
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: doc/ifetch_prefetch_unit.md
Name: ifetch_prefetch_unit

Overview:
Instruction-fetch stage with a small in-order prefetch queue. It sits directly upstream of the single-cycle decode/execute datapath and owns the PC. It issues word fetches to instruction memory over a valid/ready request channel and buffers the returned words. It hands them downstream one per cycle and redirects on the Branch/zero/Jump results of the instruction being consumed.

Parameters:
DEPTH, 4, queue entries (power of 2, ≥2); bounds queued plus in-flight fetches.
RESET_PC, 32'h0000_0000, PC loaded at reset.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-low reset (0 = reset)
imem_req  output  1  fetch request valid
imem_addr  output  32  word-aligned fetch address
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid (in order, ≥1 cycle after accept)
imem_rdata  input  32  fetched word
Instruction  output  32  head-of-queue instruction
ins_pc  output  32  PC of Instruction
ins_valid  output  1  head entry valid
ins_ready  input  1  downstream consumes head this cycle
Branch  input  1  consumed instruction is a branch
zero  input  1  ALU zero for consumed instruction
Jump  input  1  consumed instruction is a jump
flush_cnt  output  16  redirect counter (optional feature)
stall_cnt  output  16  empty-queue cycle counter (optional feature)

Behaviour:
- Reset (reset==0 at posedge): fetch_pc=RESET_PC, queue empty, FSM=IDLE, imem_req=0, ins_valid=0, Instruction=0, ins_pc=0, counters=0. Applies mid-transaction: any pending response is ignored until the next accepted request.
- Consume = ins_valid & ins_ready. pc4 = ins_pc+4.
- Redirect = consume & (Jump | (Branch & zero)). Jump has priority.
  - Jump target = {pc4[31:28], Instruction[25:0], 2'b00}.
  - Branch target = pc4 + ({{14{imm16[15]}}, imm16, 2'b00}), imm16 = Instruction[15:0], 32-bit wrap.
- Redirect effect (next edge):
  - queue emptied; fetch_pc=target.
  - If a fetch is in flight, FSM→DROP; otherwise IDLE.
  - No imem_req asserted in the redirect cycle.
- FSM:
  - IDLE: imem_req=1 when occupancy+0 < DEPTH and no redirect. On imem_ready → WAIT, fetch_pc+=4.
  - WAIT: imem_req=0. On imem_rvalid, push {rdata, addr} → IDLE.
  - DROP: imem_req=0. On imem_rvalid, discard → IDLE.
  - Exactly one request outstanding at a time.
- imem_addr=fetch_pc while imem_req; imem_addr[1:0] always 00. imem_req/imem_addr stay stable until accepted, unless a redirect or reset occurs.
- Queue: circular, DEPTH entries, log2(DEPTH)+1-bit pointers.
  - Full: no request issued; responses never overflow because the in-flight slot is counted.
  - Empty: ins_valid=0.
  - Push and pop in the same cycle: occupancy unchanged.
  - Pop with redirect: flush wins.
  - Response in the same cycle as redirect: response discarded.
- Latency: request accepted at cycle N, rvalid at N+k → ins_valid at N+k+1. Empty-queue bypass is not provided.
- ins_valid stays 1 and Instruction/ins_pc stay stable until consumed or flushed.
- fetch_pc wraps at 32'hFFFF_FFFC→0.

Optional Feature:
IFETCH_PERF_CNT_EN.
- Defined:
  - flush_cnt increments on each redirect.
  - stall_cnt increments each cycle ins_valid==0 and reset==1.
  - Both saturate at 16'hFFFF; both clear on reset.
- Undefined: both outputs tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, imem_ready=1, 1-cycle response → imem_addr sequence 0x00400000, 0x00400004, …; first ins_valid with ins_pc=0x00400000 three cycles after reset release.
- ins_ready=0 with DEPTH=4 → exactly 4 requests issued, then imem_req=0. Raise ins_ready → one pop per cycle and refetch resumes.
- Head at 0x00400008 = beq, imm16=16'hFFFE, Branch=1, zero=1 → queue flushed, next imem_addr=0x00400004, next ins_pc=0x00400004.
- Head at 0x00400010 = j with target 26'h0100010, Jump=1, fetch in flight → in-flight response dropped, next ins_pc=0x00400040.
- Branch=1, zero=0 → no flush, sequential ins_pc continues, flush_cnt unchanged.
- reset=0 asserted while in WAIT, then stray imem_rvalid → ignored; after release, fetch restarts at RESET_PC. With IFETCH_PERF_CNT_EN: two redirects give flush_cnt=2.
